// File: rtl/qu_uop_queue.sv
// qu_uop_queue: multi-lane circular FIFO of packed micro-ops between rename and issue.
// It accepts up to ENQ_LANES writes and DEQ_LANES reads per cycle, and a one-cycle flush
// recovers from a branch mispredict.

package qu_uop;
  localparam int unsigned UOP_WIDTH = 32;
endpackage

module qu_uop_queue #(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned UOP_W     = qu_uop::UOP_WIDTH,
  parameter int unsigned ENQ_LANES = 2,
  parameter int unsigned DEQ_LANES = 2,
  parameter int unsigned CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       flush,
  input  logic [ENQ_LANES-1:0]       enq_valid,
  input  logic [ENQ_LANES*UOP_W-1:0] enq_uop,
  output logic                       enq_ready,
  output logic [DEQ_LANES-1:0]       deq_valid,
  output logic [DEQ_LANES*UOP_W-1:0] deq_uop,
  input  logic [DEQ_LANES-1:0]       deq_ready,
  output logic [CNT_W-1:0]           count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PtrW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned MaxLanes = (ENQ_LANES > DEQ_LANES) ? ENQ_LANES : DEQ_LANES;

  // Reject geometries where pointer wrap by truncation would be wrong.
  if (((DEPTH & (DEPTH - 1)) != 0) || (DEPTH < 2 * MaxLanes) ||
      (ENQ_LANES < 1) || (DEQ_LANES < 1)) begin : gen_param_check
    $fatal(1, "qu_uop_queue: DEPTH must be a power of two and >= 2*max(lanes)");
  end

  logic [PtrW-1:0]  head_q, head_d;
  logic [PtrW-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [UOP_W-1:0] mem_q [DEPTH];
  logic [UOP_W-1:0] mem_d [DEPTH];

  logic [CNT_W-1:0] free_slots;
  logic [CNT_W-1:0] n_enq;
  logic [CNT_W-1:0] n_deq;
  logic             enq_fire;

  // Status flags and the accept decision, all from registered occupancy only.
  always_comb begin
    free_slots = CNT_W'(DEPTH) - count_q;
    enq_ready  = (free_slots >= CNT_W'(ENQ_LANES));
    full       = (count_q == CNT_W'(DEPTH));
    empty      = (count_q == '0);
    count      = count_q;
    enq_fire   = enq_ready && !flush;
  end

  // Per-lane output valid and combinational storage read; idle lanes drive zero.
  always_comb begin
    deq_valid = '0;
    deq_uop   = '0;
    for (int i = 0; i < DEQ_LANES; i++) begin
      deq_valid[i] = (count_q > CNT_W'(i));
      if (deq_valid[i]) begin
        deq_uop[i*UOP_W +: UOP_W] = mem_q[head_q + PtrW'(i)];
      end
    end
  end

  // Number of lanes actually transferred in each direction this cycle.
  always_comb begin
    n_enq = '0;
    n_deq = '0;
    for (int i = 0; i < ENQ_LANES; i++) begin
      if (enq_valid[i]) begin
        n_enq = n_enq + 1'b1;
      end
    end
    for (int i = 0; i < DEQ_LANES; i++) begin
      if (deq_ready[i] && deq_valid[i]) begin
        n_deq = n_deq + 1'b1;
      end
    end
    if (!enq_fire) begin
      n_enq = '0;
    end
    if (flush) begin
      n_deq = '0;
    end
  end

  // Storage write: lane i lands at tail+i, wrapping through pointer truncation.
  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < ENQ_LANES; i++) begin
      if (CNT_W'(i) < n_enq) begin
        mem_d[tail_q + PtrW'(i)] = enq_uop[i*UOP_W +: UOP_W];
      end
    end
  end

  // Pointer and occupancy next state; flush collapses the queue to empty.
  always_comb begin
    head_d  = head_q + PtrW'(n_deq);
    tail_d  = tail_q + PtrW'(n_enq);
    count_d = count_q + n_enq - n_deq;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage carries no reset; stale entries are never visible past count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Valid/ready lanes must form a contiguous run starting at lane 0.
  a_enq_contig : assert property (@(posedge clk) disable iff (!rstn)
    ((enq_valid & (enq_valid + 1'b1)) == '0))
    else $error("qu_uop_queue: non-contiguous enq_valid %b", enq_valid);

  a_deq_contig : assert property (@(posedge clk) disable iff (!rstn)
    ((deq_ready & (deq_ready + 1'b1)) == '0))
    else $error("qu_uop_queue: non-contiguous deq_ready %b", deq_ready);

  a_count_bound : assert property (@(posedge clk) disable iff (!rstn)
    (count_q <= CNT_W'(DEPTH)))
    else $error("qu_uop_queue: occupancy out of range %0d", count_q);

endmodule
